// File: rtl/led_pattern_pkg.sv
// Shared definitions for the LED pattern engine.
// Purpose: pattern mode encodings, BAR fill/drain state encoding and the
//          step-period helper used by both the step timer and the engine.
// Ports:   none (package).
package led_pattern_pkg;

  typedef enum logic [1:0] {
    MODE_ROTATE = 2'd0,
    MODE_BOUNCE = 2'd1,
    MODE_BAR    = 2'd2,
    MODE_BLINK  = 2'd3
  } mode_t;

  typedef enum logic {
    BAR_FILL  = 1'b0,
    BAR_DRAIN = 1'b1
  } bar_state_t;

  // Step period in clock cycles for a given speed setting.
  function automatic int unsigned speed_period(input int unsigned base,
                                               input logic [1:0] shift);
    return base >> shift;
  endfunction

endpackage

// File: rtl/led_pattern_engine_step_timer.sv
// Step timer for the LED pattern engine.
// Purpose: counts 0..P-1 with P = STEP_CYCLES >> shift and flags the
//          terminal count so the engine can advance on the following edge.
// Ports:   clk   - system clock (rising edge)
//          rst   - asynchronous active-high reset
//          pause - 1 freezes the count and suppresses steps
//          shift - speed select, sampled at reset release and at each wrap
//          step  - one-cycle pulse while the count sits at P-1 (not paused)
module step_timer
  import led_pattern_pkg::*;
#(
  parameter int unsigned STEP_CYCLES = 25000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pause,
  input  logic [1:0] shift,
  output logic       step
);

  localparam int CW = $clog2(STEP_CYCLES);

  logic [CW-1:0] count;
  logic [1:0]    cur_shift;
  logic          primed;
  logic [1:0]    eff_shift;
  logic [CW-1:0] last;

  // Until the first edge after reset the stored speed is not yet valid, so
  // the live input defines the first period.
  assign eff_shift = primed ? cur_shift : shift;
  assign last      = CW'(speed_period(STEP_CYCLES, eff_shift) - 1);
  assign step      = !pause && (count == last);

  // The speed is re-sampled only when a period completes, so a change
  // mid-period never stretches or shortens the period in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count     <= '0;
      cur_shift <= '0;
      primed    <= 1'b0;
    end else begin
      primed <= 1'b1;
      if (!primed || step) begin
        cur_shift <= shift;
      end
      if (!pause) begin
        count <= step ? '0 : count + CW'(1);
      end
    end
  end

endmodule

// File: rtl/led_pattern_engine.sv
// LED pattern engine.
// Purpose: drives LED_NUM LEDs with ROTATE, BOUNCE, BAR or BLINK patterns,
//          advancing one pattern step per step-timer period.
// Ports:   sys_clk    - system clock (rising edge)
//          sys_rst    - asynchronous active-high reset
//          mode       - pattern select (ROTATE/BOUNCE/BAR/BLINK)
//          dir        - 0 toward higher index, 1 toward lower (ROTATE, BAR)
//          speed      - step period = STEP_CYCLES >> speed
//          pause      - 1 freezes timer and pattern
//          led        - LED drive at LED_ON_LVL polarity
//          step_pulse - one-cycle pulse on every pattern step
module led_pattern_engine
  import led_pattern_pkg::*;
#(
  parameter int LED_NUM     = 5,
  parameter int STEP_CYCLES = 25000000,
  parameter int LED_ON_LVL  = 1
) (
  input  logic               sys_clk,
  input  logic               sys_rst,
  input  logic [1:0]         mode,
  input  logic               dir,
  input  logic [1:0]         speed,
  input  logic               pause,
  output logic [LED_NUM-1:0] led,
  output logic               step_pulse
);

  localparam logic [LED_NUM-1:0] LSB_ONE = LED_NUM'(1);
  localparam logic [LED_NUM-1:0] MSB_ONE = {1'b1, {(LED_NUM-1){1'b0}}};

  logic               step;
  logic [LED_NUM-1:0] pat;
  logic               bounce_up;
  bar_state_t         bar_state;
  mode_t              cur_mode;
  logic               cur_dir;

  mode_t              new_mode;
  logic               onehot;
  logic               reseed;
  logic [LED_NUM-1:0] rot_next;
  logic [LED_NUM-1:0] bar_fill;
  logic [LED_NUM-1:0] bar_drain;

  step_timer #(
    .STEP_CYCLES(STEP_CYCLES)
  ) u_step_timer (
    .clk  (sys_clk),
    .rst  (sys_rst),
    .pause(pause),
    .shift(speed),
    .step (step)
  );

  assign new_mode = mode_t'(mode);
  assign onehot   = (pat != '0) && ((pat & (pat - LSB_ONE)) == '0);

  // A mode change, a BAR direction change or a corrupted single-dot pattern
  // restarts the pattern from its seed instead of advancing it.
  assign reseed = (new_mode != cur_mode) ||
                  ((new_mode == MODE_BAR) && (dir != cur_dir)) ||
                  (((new_mode == MODE_ROTATE) || (new_mode == MODE_BOUNCE)) && !onehot);

  assign rot_next  = dir ? {pat[0], pat[LED_NUM-1:1]} : {pat[LED_NUM-2:0], pat[LED_NUM-1]};
  assign bar_fill  = dir ? {1'b1, pat[LED_NUM-1:1]}   : {pat[LED_NUM-2:0], 1'b1};
  assign bar_drain = dir ? {1'b0, pat[LED_NUM-1:1]}   : {pat[LED_NUM-2:0], 1'b0};

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      pat        <= LSB_ONE;
      bounce_up  <= 1'b1;
      bar_state  <= BAR_FILL;
      step_pulse <= 1'b0;
      cur_mode   <= MODE_ROTATE;
      cur_dir    <= 1'b0;
    end else begin
      step_pulse <= step;
      if (step) begin
        cur_mode <= new_mode;
        cur_dir  <= dir;
        if (reseed) begin
          bounce_up <= 1'b1;
          bar_state <= BAR_FILL;
          case (new_mode)
            MODE_ROTATE: pat <= dir ? MSB_ONE : LSB_ONE;
            MODE_BOUNCE: pat <= LSB_ONE;
            MODE_BAR:    pat <= '0;
            default:     pat <= '1;
          endcase
        end else begin
          case (new_mode)
            MODE_ROTATE: pat <= rot_next;
            MODE_BOUNCE: begin
              // Endpoints reverse direction on the step that leaves them,
              // so each end stays lit for exactly one step.
              if (bounce_up) begin
                if (pat[LED_NUM-1]) begin
                  bounce_up <= 1'b0;
                  pat       <= pat >> 1;
                end else begin
                  pat <= pat << 1;
                end
              end else begin
                if (pat[0]) begin
                  bounce_up <= 1'b1;
                  pat       <= pat << 1;
                end else begin
                  pat <= pat >> 1;
                end
              end
            end
            MODE_BAR: begin
              if (bar_state == BAR_FILL) begin
                if (&pat) begin
                  bar_state <= BAR_DRAIN;
                  pat       <= bar_drain;
                end else begin
                  pat <= bar_fill;
                end
              end else begin
                if (~|pat) begin
                  bar_state <= BAR_FILL;
                  pat       <= bar_fill;
                end else begin
                  pat <= bar_drain;
                end
              end
            end
            default: pat <= ~pat;
          endcase
        end
      end
    end
  end

  assign led = (LED_ON_LVL != 0) ? pat : ~pat;

endmodule

// File: tb/tb_led_pattern_engine.sv
// Self-checking bench for led_pattern_engine.
// Purpose: two instances (active-high and active-low LED drive) share all
//          inputs; expected LED values are queued as stimulus is applied and
//          compared whenever step_pulse appears.
// Ports:   none (top-level bench).
module tb_led_pattern_engine;

  logic       sys_clk = 1'b0;
  logic       sys_rst = 1'b1;
  logic [1:0] mode    = 2'd0;
  logic       dir     = 1'b0;
  logic [1:0] speed   = 2'd0;
  logic       pause   = 1'b0;
  logic [4:0] led;
  logic [4:0] led_n;
  logic       step_pulse;
  logic       step_pulse_n;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int last_step_cyc = 0;
  logic [4:0] exp_q[$];

  led_pattern_engine #(.LED_NUM(5), .STEP_CYCLES(8), .LED_ON_LVL(1)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .mode(mode), .dir(dir),
    .speed(speed), .pause(pause), .led(led), .step_pulse(step_pulse)
  );

  led_pattern_engine #(.LED_NUM(5), .STEP_CYCLES(8), .LED_ON_LVL(0)) dut_n (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .mode(mode), .dir(dir),
    .speed(speed), .pause(pause), .led(led_n), .step_pulse(step_pulse_n)
  );

  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for the next step, then checks its spacing from the
  // previous step and the queued LED value on both instances.
  task automatic wait_step(input string tag, input int exp_interval);
    int n;
    logic [4:0] exp_led;
    logic [4:0] exp_led_n;
    n = 0;
    do begin
      @(negedge sys_clk);
      n++;
    end while (step_pulse !== 1'b1 && n < 40);
    check_output({tag, "_pulse"}, 32'(step_pulse), 32'd1);
    check_output({tag, "_pulse_n"}, 32'(step_pulse_n), 32'd1);
    check_output({tag, "_interval"}, cyc - last_step_cyc, exp_interval);
    last_step_cyc = cyc;
    if (exp_q.size() == 0) begin
      check_output({tag, "_queue_empty"}, 32'd0, 32'd1);
    end else begin
      exp_led   = exp_q.pop_front();
      exp_led_n = ~exp_led;
      check_output({tag, "_led"}, 32'(led), 32'(exp_led));
      check_output({tag, "_led_n"}, 32'(led_n), 32'(exp_led_n));
    end
  endtask

  task automatic expect_step(input string tag, input logic [4:0] exp_led, input int exp_interval);
    exp_q.push_back(exp_led);
    wait_step(tag, exp_interval);
  endtask

  logic [4:0] rot_seq [5]  = '{5'b00010, 5'b00100, 5'b01000, 5'b10000, 5'b00001};
  logic [4:0] bnc_seq [11] = '{5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b10000, 5'b01000,
                               5'b00100, 5'b00010, 5'b00001, 5'b00010, 5'b00100};
  logic [4:0] bar_seq [12] = '{5'b00000, 5'b10000, 5'b11000, 5'b11100, 5'b11110, 5'b11111,
                               5'b01111, 5'b00111, 5'b00011, 5'b00001, 5'b00000, 5'b10000};

  initial begin
    // Reset state
    repeat (3) @(negedge sys_clk);
    check_output("reset_led", 32'(led), 32'h01);
    check_output("reset_led_n", 32'(led_n), 32'h1E);
    check_output("reset_step", 32'(step_pulse), 32'd0);

    // ROTATE dir=0 from reset release
    sys_rst = 1'b0;
    last_step_cyc = cyc;
    for (int i = 0; i < 5; i++) begin
      expect_step($sformatf("rotate%0d", i), rot_seq[i], 8);
      if (i == 0) begin
        @(negedge sys_clk);
        check_output("pulse_width", 32'(step_pulse), 32'd0);
      end
    end

    // BOUNCE: seed step then bit index 1,2,3,4,3,2,1,0,1,2
    mode = 2'd1;
    for (int i = 0; i < 11; i++) expect_step($sformatf("bounce%0d", i), bnc_seq[i], 8);

    // BAR dir=1 from mode switch
    mode = 2'd2;
    dir  = 1'b1;
    for (int i = 0; i < 12; i++) expect_step($sformatf("bar%0d", i), bar_seq[i], 8);

    // Speed change at count 3: current period intact, following ones shorter
    repeat (3) @(negedge sys_clk);
    speed = 2'd2;
    expect_step("speed_cur", 5'b11000, 8);
    expect_step("speed_new0", 5'b11100, 2);
    expect_step("speed_new1", 5'b11110, 2);

    // Pause for 5 cycles mid-period
    @(negedge sys_clk);
    pause = 1'b1;
    repeat (5) @(negedge sys_clk);
    check_output("pause_no_step", 32'(step_pulse), 32'd0);
    pause = 1'b0;
    expect_step("pause_resume", 5'b11111, 7);

    // BLINK; speed back to 0 takes effect after the current 2-cycle period
    mode  = 2'd3;
    speed = 2'd0;
    expect_step("blink_seed", 5'b11111, 2);
    expect_step("blink0", 5'b00000, 8);
    expect_step("blink1", 5'b11111, 8);

    // Asynchronous reset mid-period
    repeat (3) @(negedge sys_clk);
    sys_rst = 1'b1;
    #1;
    check_output("async_led", 32'(led), 32'h01);
    check_output("async_led_n", 32'(led_n), 32'h1E);
    check_output("async_step", 32'(step_pulse), 32'd0);
    repeat (2) @(negedge sys_clk);
    sys_rst = 1'b0;
    last_step_cyc = cyc;
    expect_step("post_reset_seed", 5'b11111, 8);
    expect_step("post_reset_blink", 5'b00000, 8);

    // ROTATE reseed, then dir change without reseed
    mode = 2'd0;
    dir  = 1'b0;
    expect_step("rot_seed", 5'b00001, 8);
    dir = 1'b1;
    expect_step("rot_dir0", 5'b10000, 8);
    expect_step("rot_dir1", 5'b01000, 8);

    check_output("queue_drained", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/led_pattern_engine.md
LED_PATTERN_ENGINE -- requirements
Module: led_pattern_engine

Interface
REQ-001 The block SHALL have parameter LED_NUM, default 5, number of LED outputs (legal range 2..32).
REQ-002 The block SHALL have parameter STEP_CYCLES, default 25000000, base step period in sys_clk cycles (legal minimum 8).
REQ-003 The block SHALL have parameter LED_ON_LVL, default 1, output level driven for a lit LED.
REQ-004 The block SHALL have port sys_clk  input  1  single system clock; all logic on its rising edge.
REQ-005 The block SHALL have port sys_rst  input  1  one clock; reset asynchronous, active-high.
REQ-006 The block SHALL have port mode  input  2  pattern select: 0 ROTATE, 1 BOUNCE, 2 BAR, 3 BLINK.
REQ-007 The block SHALL have port dir  input  1  0 = toward higher index, 1 = toward lower index (ROTATE and BAR only).
REQ-008 The block SHALL have port speed  input  2  step period = STEP_CYCLES >> speed cycles.
REQ-009 The block SHALL have port pause  input  1  1 = freeze timer and pattern.
REQ-010 The block SHALL have port led  output  LED_NUM  LED drive, registered.
REQ-011 The block SHALL have port step_pulse  output  1  one-cycle high on every pattern step, registered.

Function
REQ-012 Internal pattern register pat[LED_NUM-1:0] SHALL hold logical on-state (1 = lit); led SHALL equal pat when LED_ON_LVL=1 and ~pat when LED_ON_LVL=0, with no extra latency beyond pat.
REQ-013 Step timer SHALL count 0..P-1 with P = STEP_CYCLES >> speed, wrap to 0, and assert step_pulse in the cycle after count equals P-1.
REQ-014 speed SHALL be sampled only at timer wrap; a change mid-period SHALL NOT truncate or extend the current period.
REQ-015 While pause=1 the timer SHALL hold its count, no step SHALL occur, and pat SHALL hold; on pause release counting SHALL resume from the held value.
REQ-016 pat SHALL update on the same edge that sets step_pulse, i.e. one sys_clk after the terminal count.
REQ-017 ROTATE: one lit LED; each step rotates pat by one position in direction dir, wrapping LED_NUM-1 -> 0 (dir=0) or 0 -> LED_NUM-1 (dir=1).
REQ-018 BOUNCE: one lit LED moving up; at bit LED_NUM-1 it reverses and moves down; at bit 0 it reverses again; endpoints are lit for exactly one step each (sequence 0,1,..,N-1,N-2,..,1,0,1,...).
REQ-019 BAR: state FILL lights one additional LED per step from the origin end (bit 0 if dir=0, bit LED_NUM-1 if dir=1) until all are lit; state DRAIN then clears one LED per step from the same end until none are lit; FILL resumes; all-lit and all-dark states each last one step.
REQ-020 BLINK: pat toggles between all-ones and all-zeros each step.
REQ-021 mode SHALL be sampled on each step; on a mode change the step SHALL load the new mode's seed instead of advancing: ROTATE/BOUNCE seed 1 at origin end (bit 0 for BOUNCE), BAR seed all-dark with state FILL, BLINK seed all-ones.
REQ-022 dir changes in ROTATE SHALL take effect at the next step without reseed; dir changes in BAR SHALL reseed as in REQ-021.
REQ-023 If pat is ever not a legal pattern for the current mode (not one-hot in ROTATE/BOUNCE), the next step SHALL load the mode seed.

Reset
REQ-024 While sys_rst=1: timer = 0, pat = 1 (bit 0 lit), BOUNCE direction = up, BAR state = FILL, step_pulse = 0, stored mode = ROTATE, stored speed = speed input value at reset release.
REQ-025 Reset asserted mid-period SHALL take effect immediately and asynchronously; the first step after release occurs exactly P cycles after the first rising edge with sys_rst=0.

Structure
REQ-026 Mode encodings, BAR state encoding, and the speed-shift function SHALL reside in shared package led_pattern_pkg.
REQ-027 The step timer (REQ-013..REQ-015) SHALL be a sub-module step_timer with outputs step (1-cycle pulse) and inputs pause and shift; pattern logic stays in led_pattern_engine.

Verification (LED_NUM=5, STEP_CYCLES=8, LED_ON_LVL=1 unless stated)
REQ-028 ROTATE, dir=0, speed=0, reset released: step_pulse every 8 cycles; led = 00010, 00100, 01000, 10000, 00001.
REQ-029 BOUNCE: led bit index sequence over 10 steps = 1,2,3,4,3,2,1,0,1,2.
REQ-030 BAR dir=1 from mode switch: led = 00000 (seed), 10000, 11000, 11100, 11110, 11111, 01111, 00111, 00011, 00001, 00000, 10000.
REQ-031 speed changed 0->2 at timer count 3: current period stays 8 cycles, following periods are 2 cycles; pause held 5 cycles mid-period delays the next step_pulse by exactly 5 cycles.
REQ-032 LED_ON_LVL=0 BLINK: led alternates 00000 / 11111 each step; sys_rst pulsed mid-period: led = 11110 immediately (async), step_pulse = 0, next step 8 cycles after release.
